// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and a width helper for all FIFO variants.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 8;
    localparam int unsigned FIFO_DEPTH  = 16;

    // Ceiling log2, usable in constant expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Write/read handshake and status bundle of param_fifo.
interface param_fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH
);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic              ren;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic [CNT_W-1:0]  count;

    modport master (
        output wen, wdata, ren,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               overflow, underflow, count
    );

    modport slave (
        input  wen, wdata, ren,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               overflow, underflow, count
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array; stale contents are hidden by the pointer/flag logic.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO: pointer/count/flag control with registered or first-word-fall-through read.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = FIFO_DATA_W,
    parameter int unsigned DEPTH    = FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input  logic          clk,
    input  logic          reset,
    param_fifo_if.slave   bus
);

    localparam int unsigned AW    = clog2(DEPTH);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_n_c;
    logic              full_q;
    logic              empty_q;
    logic              af_q;
    logic              ae_q;
    logic              ovf_q;
    logic              udf_q;
    logic              wr_ok_c;
    logic              rd_ok_c;
    logic [DATA_W-1:0] mem_rdata;

    // Acceptance is judged against the registered flags; full+wen+ren keeps only the read.
    always_comb begin
        wr_ok_c   = bus.wen && !full_q;
        rd_ok_c   = bus.ren && !empty_q;
        count_n_c = count_q;
        if (wr_ok_c && !rd_ok_c) begin
            count_n_c = count_q + CNT_W'(1);
        end else if (!wr_ok_c && rd_ok_c) begin
            count_n_c = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= (AF_LEVEL == 0);
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_ok_c) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_ok_c) begin
                rptr <= rptr + AW'(1);
            end
            count_q <= count_n_c;
            full_q  <= (32'(count_n_c) == DEPTH);
            empty_q <= (count_n_c == '0);
            af_q    <= (32'(count_n_c) >= AF_LEVEL);
            ae_q    <= (32'(count_n_c) <= AE_LEVEL);
            ovf_q   <= bus.wen && full_q;
            udf_q   <= bus.ren && empty_q;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok_c && !reset),
        .waddr (wptr),
        .wdata (bus.wdata),
        .raddr (rptr),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_W-1:0] rdata_q;
            logic              rvalid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_ok_c;
                    if (rd_ok_c) begin
                        rdata_q <= mem_rdata;
                    end
                end
            end

            assign bus.rdata  = rdata_q;
            assign bus.rvalid = rvalid_q;
        end else begin : g_fwft
            // Head word shown directly; masked to zero while empty so stale memory never leaks.
            assign bus.rdata  = empty_q ? '0 : mem_rdata;
            assign bus.rvalid = !empty_q;
        end
    endgenerate

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
    assign bus.count        = count_q;

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: registered-read and FWFT instances driven in lockstep.
module tb_param_fifo;

    bit clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    param_fifo_if #(.DATA_W(8), .DEPTH(16)) b0 ();
    param_fifo_if #(.DATA_W(8), .DEPTH(16)) b1 ();

    param_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    param_fifo #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mdl  [$];   // words the FIFO should be holding
    logic [7:0] exp0 [$];   // words the registered-read port still owes

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: registered port pops the scoreboard on rvalid; FWFT port must show the model head.
    always @(negedge clk) begin
        if (b0.rvalid === 1'b1) begin
            if (exp0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rdata0_spurious: got rvalid with data 0x%0h, expected no word at %0t", b0.rdata, $time);
            end else begin
                chk("rdata0", int'(b0.rdata), int'(exp0.pop_front()));
            end
        end
        if (reset === 1'b0) begin
            chk("rvalid1", int'(b1.rvalid), int'(mdl.size() != 0));
            if (mdl.size() != 0) begin
                chk("rdata1", int'(b1.rdata), int'(mdl[0]));
            end
        end
    end

    task automatic drive(input bit w, input int d, input bit r);
        b0.wen = w;  b1.wen = w;
        b0.ren = r;  b1.ren = r;
        b0.wdata = 8'(d);
        b1.wdata = 8'(d);
    endtask

    task automatic check_state(input bit eo, input bit eu);
        int n;
        n = mdl.size();
        chk("count0", int'(b0.count), n);
        chk("count1", int'(b1.count), n);
        chk("full0",  int'(b0.full),  int'(n == 16));
        chk("empty0", int'(b0.empty), int'(n == 0));
        chk("empty1", int'(b1.empty), int'(n == 0));
        chk("af0",    int'(b0.almost_full),  int'(n >= 14));
        chk("ae0",    int'(b0.almost_empty), int'(n <= 2));
        chk("ovf0",   int'(b0.overflow),  int'(eo));
        chk("udf0",   int'(b0.underflow), int'(eu));
        chk("ovf1",   int'(b1.overflow),  int'(eo));
        chk("udf1",   int'(b1.underflow), int'(eu));
    endtask

    // One clock with optional write/read; model decides acceptance from its own occupancy.
    task automatic cyc(input bit w, input int d, input bit r);
        int n;
        bit wa, ra, eo, eu;
        n  = mdl.size();
        wa = w && (n < 16);
        ra = r && (n > 0);
        eo = w && (n == 16);
        eu = r && (n == 0);
        drive(w, d, r);
        @(posedge clk);
        #1;
        if (ra) exp0.push_back(mdl.pop_front());
        if (wa) mdl.push_back(8'(d));
        drive(1'b0, 0, 1'b0);
        chk("rvalid0", int'(b0.rvalid), int'(ra));
        check_state(eo, eu);
    endtask

    // Reset with wen/ren held high: both must be ignored and raise no error pulse.
    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 8'h55, 1'b1);
        @(posedge clk);
        #1;
        mdl.delete();
        exp0.delete();
        drive(1'b0, 0, 1'b0);
        chk("rst_rvalid0", int'(b0.rvalid), 0);
        chk("rst_rdata0",  int'(b0.rdata),  0);
        chk("rst_rvalid1", int'(b1.rvalid), 0);
        chk("rst_rdata1",  int'(b1.rdata),  0);
        check_state(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 0, 1'b0);
        do_reset();

        // Fill 1..16, almost_full from count 14, full on the 16th edge
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, i, 1'b0);
            if (i == 13) chk("af_at_13", int'(b0.almost_full), 0);
            if (i == 14) chk("af_at_14", int'(b0.almost_full), 1);
            if (i == 15) chk("full_at_15", int'(b0.full), 0);
        end
        chk("count_16", int'(b0.count), 16);
        chk("full_16", int'(b0.full), 1);
        cyc(1'b1, 17, 1'b0);
        chk("ovf_17th", int'(b0.overflow), 1);
        chk("count_stays_16", int'(b0.count), 16);

        // Drain in order, then one extra read underflows
        for (int i = 1; i <= 16; i++) cyc(1'b0, 0, 1'b1);
        chk("empty_after_drain", int'(b0.empty), 1);
        cyc(1'b0, 0, 1'b1);
        chk("udf_extra_read", int'(b0.underflow), 1);

        // Wrap: 10 in/out, then 100..111 straddle the pointer wrap
        for (int i = 0; i < 10; i++) cyc(1'b1, 200 + i, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 0, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b1, 100 + i, 1'b0);
        chk("count_wrap_12", int'(b0.count), 12);
        for (int i = 0; i < 12; i++) cyc(1'b0, 0, 1'b1);

        // Simultaneous write+read at occupancy 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 50 + i, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 60 + i, 1'b1);
        chk("count_sim_5", int'(b0.count), 5);

        // Full with wen+ren: read wins, overflow
        for (int i = 0; i < 11; i++) cyc(1'b1, 130 + i, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1);
        chk("count_full_rw", int'(b0.count), 15);
        chk("ovf_full_rw", int'(b0.overflow), 1);

        // Empty with wen+ren: write wins, underflow
        for (int i = 0; i < 15; i++) cyc(1'b0, 0, 1'b1);
        cyc(1'b1, 8'h77, 1'b1);
        chk("count_empty_rw", int'(b0.count), 1);
        chk("udf_empty_rw", int'(b0.underflow), 1);
        cyc(1'b0, 0, 1'b1);

        // FWFT: word falls through right after the write edge
        cyc(1'b1, 8'hA5, 1'b0);
        chk("fwft_rdata", int'(b1.rdata), 8'hA5);
        chk("fwft_rvalid", int'(b1.rvalid), 1);
        cyc(1'b0, 0, 1'b1);
        chk("fwft_empty_pop", int'(b1.empty), 1);
        chk("fwft_rvalid_pop", int'(b1.rvalid), 0);

        // Reset at count 9 discards contents; traffic resumes cleanly
        for (int i = 0; i < 9; i++) cyc(1'b1, 20 + i, 1'b0);
        chk("count_9", int'(b0.count), 9);
        do_reset();
        cyc(1'b1, 8'h3C, 1'b0);
        chk("post_rst_fwft", int'(b1.rdata), 8'h3C);
        cyc(1'b0, 0, 1'b1);
        chk("post_rst_rdata0", int'(b0.rdata), 8'h3C);
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);

        chk("scoreboard_drained", exp0.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
